// File: rtl/updown_step_sequencer.sv
// Command sequencer for a saturating up/down counter: accepts a target count and
// issues single-cycle step pulses until its internal model of the counter matches.
module updown_step_sequencer #(
    parameter int WIDTH     = 2,
    parameter int MAX_COUNT = 3,
    parameter int GAP       = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tgt_valid,
    output logic             tgt_ready,
    input  logic [WIDTH-1:0] tgt_value,
    input  logic             clr_req,
    output logic             step_en,
    output logic             step_up,
    output logic             clr_out,
    output logic [WIDTH-1:0] cur_count,
    output logic             busy,
    output logic             done
);

    localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
    localparam logic [WIDTH-1:0] MAX_C    = WIDTH'(MAX_COUNT);
    localparam logic [GW-1:0]    GAP_LOAD = (GAP > 0) ? GW'(GAP - 1) : '0;

    typedef enum logic [1:0] {S_IDLE, S_STEP, S_GAP, S_DONE} state_t;

    state_t           state_reg;
    logic [WIDTH-1:0] cur_count_reg;
    logic [WIDTH-1:0] tgt_reg;
    logic [GW-1:0]    gap_cnt_reg;
    logic             step_up_reg;
    logic             clr_out_reg;

    logic [WIDTH-1:0] tgt_clamped;
    logic [WIDTH-1:0] count_next;

    // Oversized requests saturate at the counter ceiling rather than wrapping.
    always_comb begin
        tgt_clamped = (tgt_value > MAX_C) ? MAX_C : tgt_value;
        count_next  = step_up_reg ? cur_count_reg + WIDTH'(1) : cur_count_reg - WIDTH'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= S_IDLE;
            cur_count_reg <= '0;
            tgt_reg       <= '0;
            gap_cnt_reg   <= '0;
            step_up_reg   <= 1'b0;
            clr_out_reg   <= 1'b0;
        end else if (clr_req) begin
            // Clear aborts any sequence silently; no done pulse follows.
            state_reg     <= S_IDLE;
            cur_count_reg <= '0;
            gap_cnt_reg   <= '0;
            clr_out_reg   <= 1'b1;
        end else begin
            clr_out_reg <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    if (tgt_valid) begin
                        tgt_reg <= tgt_clamped;
                        if (tgt_clamped == cur_count_reg) begin
                            state_reg <= S_DONE;
                        end else begin
                            state_reg   <= S_STEP;
                            step_up_reg <= (tgt_clamped > cur_count_reg);
                        end
                    end
                end
                S_STEP: begin
                    cur_count_reg <= count_next;
                    if (GAP > 0) begin
                        state_reg   <= S_GAP;
                        gap_cnt_reg <= GAP_LOAD;
                    end else if (count_next != tgt_reg) begin
                        state_reg   <= S_STEP;
                        step_up_reg <= (tgt_reg > count_next);
                    end else begin
                        state_reg <= S_DONE;
                    end
                end
                S_GAP: begin
                    if (gap_cnt_reg == '0) begin
                        if (cur_count_reg != tgt_reg) begin
                            state_reg   <= S_STEP;
                            step_up_reg <= (tgt_reg > cur_count_reg);
                        end else begin
                            state_reg <= S_DONE;
                        end
                    end else begin
                        gap_cnt_reg <= gap_cnt_reg - GW'(1);
                    end
                end
                S_DONE: begin
                    state_reg <= S_IDLE;
                end
                default: begin
                    state_reg <= S_IDLE;
                end
            endcase
        end
    end

    assign tgt_ready = (state_reg == S_IDLE) && !clr_req;
    assign step_en   = (state_reg == S_STEP);
    assign step_up   = step_up_reg;
    assign clr_out   = clr_out_reg;
    assign cur_count = cur_count_reg;
    assign busy      = (state_reg == S_STEP) || (state_reg == S_GAP);
    assign done      = (state_reg == S_DONE);

endmodule

// File: tb/tb_updown_step_sequencer.sv
// Directed bench for updown_step_sequencer: default build, a wider clamped build,
// and a zero-gap build exercised through a mid-sequence reset.
module tb_updown_step_sequencer;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Default build: WIDTH=2, MAX_COUNT=3, GAP=1
    logic       a_valid, a_ready, a_clr_req, a_en, a_up, a_clr, a_busy, a_done;
    logic [1:0] a_value, a_count;
    // Wide build: WIDTH=3, MAX_COUNT=5, GAP=1
    logic       w_valid, w_ready, w_clr_req, w_en, w_up, w_clr, w_busy, w_done;
    logic [2:0] w_value, w_count;
    // Back-to-back build: WIDTH=2, MAX_COUNT=3, GAP=0
    logic       g_valid, g_ready, g_clr_req, g_en, g_up, g_clr, g_busy, g_done;
    logic [1:0] g_value, g_count;

    updown_step_sequencer #(.WIDTH(2), .MAX_COUNT(3), .GAP(1)) dut_a (
        .clk(clk), .reset(reset), .tgt_valid(a_valid), .tgt_ready(a_ready),
        .tgt_value(a_value), .clr_req(a_clr_req), .step_en(a_en), .step_up(a_up),
        .clr_out(a_clr), .cur_count(a_count), .busy(a_busy), .done(a_done)
    );

    updown_step_sequencer #(.WIDTH(3), .MAX_COUNT(5), .GAP(1)) dut_w (
        .clk(clk), .reset(reset), .tgt_valid(w_valid), .tgt_ready(w_ready),
        .tgt_value(w_value), .clr_req(w_clr_req), .step_en(w_en), .step_up(w_up),
        .clr_out(w_clr), .cur_count(w_count), .busy(w_busy), .done(w_done)
    );

    updown_step_sequencer #(.WIDTH(2), .MAX_COUNT(3), .GAP(0)) dut_g (
        .clk(clk), .reset(reset), .tgt_valid(g_valid), .tgt_ready(g_ready),
        .tgt_value(g_value), .clr_req(g_clr_req), .step_en(g_en), .step_up(g_up),
        .clr_out(g_clr), .cur_count(g_count), .busy(g_busy), .done(g_done)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_a_idle(input string tag, input logic [1:0] cnt);
        chk({tag, "_en"},    a_en,    1'b0);
        chk({tag, "_busy"},  a_busy,  1'b0);
        chk({tag, "_done"},  a_done,  1'b0);
        chk({tag, "_ready"}, a_ready, 1'b1);
        chk({tag, "_count"}, a_count, cnt);
    endtask

    initial begin
        reset = 1'b1;
        a_valid = 0; a_value = 0; a_clr_req = 0;
        w_valid = 0; w_value = 0; w_clr_req = 0;
        g_valid = 0; g_value = 0; g_clr_req = 0;
        tick(); tick();
        reset = 1'b0;

        // Reset state
        chk("rst_up", a_up, 1'b0);
        chk("rst_clr", a_clr, 1'b0);
        chk_a_idle("rst", 2'd0);
        $display("txn reset: count=%0d ready=%0d", a_count, a_ready);

        // 0 -> 3: three up steps spaced two cycles apart
        a_valid = 1; a_value = 2'd3;
        tick();
        a_valid = 0;
        chk("up3_ready_busy", a_ready, 1'b0);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("up3_s%0d_en", i), a_en, 1'b1);
            chk($sformatf("up3_s%0d_up", i), a_up, 1'b1);
            chk($sformatf("up3_s%0d_busy", i), a_busy, 1'b1);
            chk($sformatf("up3_s%0d_cnt", i), a_count, i);
            tick();
            chk($sformatf("up3_g%0d_en", i), a_en, 1'b0);
            chk($sformatf("up3_g%0d_cnt", i), a_count, i + 1);
            chk($sformatf("up3_g%0d_done", i), a_done, 1'b0);
            tick();
        end
        chk("up3_done", a_done, 1'b1);
        chk("up3_done_busy", a_busy, 1'b0);
        chk("up3_done_cnt", a_count, 2'd3);
        tick();
        chk_a_idle("up3_end", 2'd3);
        $display("txn target=3: count=%0d", a_count);

        // 3 -> 1: two down steps, never up
        a_valid = 1; a_value = 2'd1;
        tick();
        a_valid = 0;
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("dn1_s%0d_en", i), a_en, 1'b1);
            chk($sformatf("dn1_s%0d_up", i), a_up, 1'b0);
            chk($sformatf("dn1_s%0d_cnt", i), a_count, 3 - i);
            tick();
            chk($sformatf("dn1_g%0d_en", i), a_en, 1'b0);
            chk($sformatf("dn1_g%0d_up", i), a_up, 1'b0);
            chk($sformatf("dn1_g%0d_cnt", i), a_count, 2 - i);
            tick();
        end
        chk("dn1_done", a_done, 1'b1);
        tick();
        chk_a_idle("dn1_end", 2'd1);
        $display("txn target=1: count=%0d", a_count);

        // 1 -> 2 (single step), then target equal to count: zero steps
        a_valid = 1; a_value = 2'd2;
        tick();
        a_valid = 0;
        chk("one_en", a_en, 1'b1);
        chk("one_up", a_up, 1'b1);
        tick(); tick();
        chk("one_done", a_done, 1'b1);
        tick();
        a_valid = 1; a_value = 2'd2;
        tick();
        a_valid = 0;
        chk("zero_done", a_done, 1'b1);
        chk("zero_en", a_en, 1'b0);
        chk("zero_busy", a_busy, 1'b0);
        chk("zero_cnt", a_count, 2'd2);
        tick();
        chk_a_idle("zero_end", 2'd2);
        $display("txn target=2 equal: count=%0d", a_count);

        // clr_req together with tgt_valid: clear wins, no transfer
        a_clr_req = 1; a_valid = 1; a_value = 2'd3;
        #1;
        chk("clr_ready_low", a_ready, 1'b0);
        tick();
        a_clr_req = 0; a_valid = 0;
        chk("clr_pulse", a_clr, 1'b1);
        chk("clr_cnt", a_count, 2'd0);
        tick();
        chk("clr_pulse_end", a_clr, 1'b0);
        chk_a_idle("clr_noxfer", 2'd0);
        $display("txn clear+valid: count=%0d", a_count);

        // clr_req held two cycles: clr_out for two cycles, ready low throughout
        a_clr_req = 1;
        tick();
        chk("clrh1_pulse", a_clr, 1'b1);
        chk("clrh1_ready", a_ready, 1'b0);
        tick();
        chk("clrh2_pulse", a_clr, 1'b1);
        a_clr_req = 0;
        tick();
        chk("clrh_end", a_clr, 1'b0);
        $display("txn clear held: clr_out=%0d", a_clr);

        // Abort after the second of three steps
        a_valid = 1; a_value = 2'd3;
        tick();
        a_valid = 0;
        tick(); tick(); tick();
        chk("abort_pre_cnt", a_count, 2'd2);
        chk("abort_pre_en", a_en, 1'b0);
        a_clr_req = 1;
        tick();
        a_clr_req = 0;
        chk("abort_clr", a_clr, 1'b1);
        chk("abort_cnt", a_count, 2'd0);
        chk("abort_en", a_en, 1'b0);
        chk("abort_busy", a_busy, 1'b0);
        chk("abort_done", a_done, 1'b0);
        tick();
        chk("abort_clr_end", a_clr, 1'b0);
        chk_a_idle("abort_end", 2'd0);
        tick();
        chk("abort_no_done", a_done, 1'b0);
        $display("txn abort: count=%0d", a_count);

        // Wide build: target 7 clamps to 5
        w_valid = 1; w_value = 3'd7;
        tick();
        w_valid = 0;
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("w_s%0d_en", i), w_en, 1'b1);
            chk($sformatf("w_s%0d_up", i), w_up, 1'b1);
            chk($sformatf("w_s%0d_cnt", i), w_count, i);
            tick();
            chk($sformatf("w_g%0d_cnt", i), w_count, i + 1);
            tick();
        end
        chk("w_done", w_done, 1'b1);
        chk("w_done_cnt", w_count, 3'd5);
        tick();
        chk("w_end_cnt", w_count, 3'd5);
        chk("w_end_ready", w_ready, 1'b1);
        chk("w_end_en", w_en, 1'b0);
        $display("txn wide target=7: count=%0d", w_count);

        // Zero-gap build: back-to-back steps, then reset mid-sequence
        g_valid = 1; g_value = 2'd3;
        tick();
        g_valid = 0;
        chk("g_s0_en", g_en, 1'b1);
        chk("g_s0_cnt", g_count, 2'd0);
        tick();
        chk("g_s1_en", g_en, 1'b1);
        chk("g_s1_up", g_up, 1'b1);
        chk("g_s1_cnt", g_count, 2'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("g_rst_en", g_en, 1'b0);
        chk("g_rst_up", g_up, 1'b0);
        chk("g_rst_clr", g_clr, 1'b0);
        chk("g_rst_cnt", g_count, 2'd0);
        chk("g_rst_busy", g_busy, 1'b0);
        chk("g_rst_done", g_done, 1'b0);
        chk("g_rst_ready", g_ready, 1'b1);
        tick();
        chk("g_post_done", g_done, 1'b0);
        chk("g_post_en", g_en, 1'b0);
        $display("txn gap0 reset: count=%0d", g_count);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/updown_step_sequencer.md
Name: updown_step_sequencer

Overview:
- Command-side companion to the 2-bit up/down counter.
- Accepts a target count over a valid/ready handshake and drives the counter's control inputs: enable (SW[1] role), direction (SW[0] role) and clear (SW[17] role). Issues one single-cycle step command at a time until its internal model of the counter equals the target.
- Sits between the switch/command front end and the counter; the counter's current value is reconstructed internally and exported, never read back.

Parameters:
- WIDTH, 2, width of count and target.
- MAX_COUNT, 3, saturation ceiling of the driven counter. Must be ≤ 2^WIDTH−1.
- GAP, 1, idle cycles inserted after each step pulse. 0 means back-to-back steps.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- tgt_valid  input  1  target offered
- tgt_ready  output  1  sequencer can accept a target
- tgt_value  input  WIDTH  requested count
- clr_req  input  1  request counter clear
- step_en  output  1  step command pulse (counter enable)
- step_up  output  1  direction for the step: 1 = up, 0 = down
- clr_out  output  1  clear pulse to counter
- cur_count  output  WIDTH  modelled counter value
- busy  output  1  sequence in progress
- done  output  1  one-cycle pulse when target is reached

Behaviour:
- Reset (reset=1 at a clk edge):
  - Outputs: state=IDLE, cur_count=0, step_en=0, step_up=0, clr_out=0, busy=0, done=0, tgt_ready=1.
  - Reset overrides all other inputs in that cycle.
- States: IDLE, STEP, GAP, DONE.
- tgt_ready = 1 only in IDLE with clr_req=0. A transfer occurs when tgt_valid & tgt_ready are both high at a clk edge.
- Target capture:
  - tgt_value > MAX_COUNT is clamped to MAX_COUNT before being stored in the tgt register.
  - busy goes high the cycle after capture.
- IDLE → DONE on capture if clamped target == cur_count (zero steps). Otherwise IDLE → STEP.
- STEP (one cycle):
  - step_en=1; step_up=1 if tgt > cur_count, else 0.
  - cur_count increments or decrements at the end of this cycle.
  - Next state: GAP if GAP>0, else STEP if cur_count(next) != tgt, else DONE.
- GAP:
  - Counts GAP cycles with step_en=0.
  - Then goes to STEP if cur_count != tgt, else DONE.
- DONE (one cycle): done=1, busy=0 → IDLE. tgt_ready returns to 1 in the following cycle.
- Step count: |tgt − cur_count|.
  - Latency from capture to done = steps·(1+GAP) + 1 cycles (GAP>0, measured from capture edge to the done cycle).
  - Zero steps: done on the cycle after capture.
- cur_count never leaves 0..MAX_COUNT. No wrap-around. step_en is never asserted with up at MAX_COUNT or down at 0.
- step_up is held at its last value while step_en=0. It is valid only when step_en=1.
- clr_req (any state, reset=0):
  - Highest priority after reset.
  - Next cycle: clr_out=1 for exactly one cycle, cur_count=0, step_en=0, state=IDLE, busy=0.
  - An in-flight sequence is aborted with no done pulse.
  - clr_req held high produces clr_out high for as many cycles as it is held; tgt_ready stays 0 during that time.
- clr_req and a tgt_valid transfer in the same cycle: no transfer occurs, because tgt_ready=0 when clr_req=1.
- tgt_valid while busy is ignored, since tgt_ready=0. The offering side must hold tgt_valid until it is accepted.
- Reset mid-sequence: immediate return to reset values; no done pulse, no clr_out pulse.

Test Plan:
- Reset then tgt_value=3 → three step_en pulses with step_up=1, spaced 2 cycles apart (GAP=1); cur_count goes 1,2,3; done pulse once; tgt_ready back to 1.
- From cur_count=3, tgt_value=1 → two pulses with step_up=0; cur_count goes 2,1; done; at no time is step_en=1 with step_up=1.
- tgt_value equal to cur_count=2 → no step_en; done exactly 1 cycle after capture.
- WIDTH=3, MAX_COUNT=5, tgt_value=7 → clamped; five up steps; cur_count stops at 5; done.
- clr_req asserted after the second of three steps → clr_out single pulse, cur_count=0, no done, tgt_ready=1 the following cycle; tgt_valid in the clr_req cycle is not accepted.
- reset asserted mid-sequence with GAP=0 → all outputs return to reset values at the next edge; back-to-back steps (GAP=0) produce step_en high on consecutive cycles before the reset.
